// File: rtl/brew_plant.sv
`default_nettype none
// ============================================================================
// Module      : brew_plant
// Description : Behavioural kettle plant driven by the brew controller.
//               Models kettle temperature, kettle level, holding-tank level,
//               grain loading and sticky plant faults on two prescaled ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module brew_plant #(
   parameter int HEAT_DIV   = 4,
   parameter int FLOW_DIV   = 2,
   parameter int FILL_RATE  = 5,
   parameter int DRAIN_RATE = 5,
   parameter int GRAIN_VOL  = 10,
   parameter int AMBIENT    = 20,
   parameter int T_MAX      = 100,
   parameter int L_MAX      = 200,
   parameter int INIT_TEMP  = 20,
   parameter int INIT_LEVEL = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       heat,
   input  logic       agitate,
   input  logic       chute,
   input  logic [2:0] pump,
   output logic [7:0] temp,
   output logic [7:0] level,
   output logic [7:0] tank_level,
   output logic       grain_loaded,
   output logic [2:0] fault
);

   localparam logic [8:0] c_FILL    = 9'(FILL_RATE);
   localparam logic [8:0] c_DRAIN   = 9'(DRAIN_RATE);
   localparam logic [8:0] c_GRAIN   = 9'(GRAIN_VOL);
   localparam logic [8:0] c_L_MAX   = 9'(L_MAX);
   localparam logic [8:0] c_AMB     = 9'(AMBIENT);
   localparam logic [8:0] c_T_MAX   = 9'(T_MAX);
   localparam logic [8:0] c_TANK_MAX = 9'd255;

   logic [15:0] r_heat_cnt;
   logic [15:0] r_flow_cnt;
   logic        r_chute_q;

   logic        w_htick;
   logic        w_ftick;
   logic        w_pump_bad;
   logic        w_cedge;
   logic        w_grain_ok;
   logic        w_level_zero;
   logic [8:0]  w_level9;
   logic [8:0]  w_tank9;
   logic [8:0]  w_temp9;
   logic [8:0]  w_add;
   logic [8:0]  w_lvl_req;
   logic [8:0]  w_tank_req;
   logic [8:0]  w_lvl_rm;
   logic [8:0]  w_tank_rm;
   logic        w_to_tank;
   logic [8:0]  w_lvl_sum;
   logic [8:0]  w_tank_sum;
   logic [7:0]  w_level_nxt;
   logic [7:0]  w_tank_nxt;
   logic [7:0]  w_temp_nxt;
   logic        w_overflow;
   logic        w_dry_fire;

   assign w_htick      = (r_heat_cnt == 16'(HEAT_DIV - 1));
   assign w_ftick      = (r_flow_cnt == 16'(FLOW_DIV - 1));
   assign w_pump_bad   = (pump == 3'b001) || (pump == 3'b110);
   assign w_cedge      = chute & ~r_chute_q;
   assign w_level_zero = (level == 8'd0);
   assign w_grain_ok   = w_cedge & ~w_level_zero;
   assign w_level9     = {1'b0, level};
   assign w_tank9      = {1'b0, tank_level};
   assign w_temp9      = {1'b0, temp};

   // Flow decode and level/tank arithmetic; removals are limited to what is present
   always_comb begin
      w_add      = 9'd0;
      w_lvl_req  = 9'd0;
      w_tank_req = 9'd0;
      w_to_tank  = 1'b0;
      if (w_ftick) begin
         case (pump)
            3'b100, 3'b111: w_add = c_FILL;
            3'b010:         w_lvl_req = c_DRAIN;
            3'b011: begin
               w_lvl_req = c_DRAIN;
               w_to_tank = 1'b1;
            end
            3'b101:         w_tank_req = c_DRAIN;
            default:        w_add = 9'd0;
         endcase
      end
      w_lvl_rm   = (w_level9 < w_lvl_req)  ? w_level9 : w_lvl_req;
      w_tank_rm  = (w_tank9  < w_tank_req) ? w_tank9  : w_tank_req;
      w_lvl_sum  = w_level9 - w_lvl_rm + w_add + w_tank_rm + (w_grain_ok ? c_GRAIN : 9'd0);
      w_tank_sum = w_tank9 - w_tank_rm + (w_to_tank ? w_lvl_rm : 9'd0);
      w_overflow = (w_lvl_sum > c_L_MAX);
      w_level_nxt = w_overflow ? c_L_MAX[7:0] : w_lvl_sum[7:0];
      w_tank_nxt  = (w_tank_sum > c_TANK_MAX) ? 8'd255 : w_tank_sum[7:0];
   end

   // Thermal model: heat toward T_MAX, otherwise relax toward ambient
   always_comb begin
      w_temp_nxt = temp;
      w_dry_fire = w_cedge & w_level_zero;
      if (w_htick) begin
         if (heat) begin
            w_temp_nxt = (w_temp9 < c_T_MAX) ? temp + 8'd1 : c_T_MAX[7:0];
            if (w_level_zero) begin
               w_dry_fire = 1'b1;
            end
         end else if (w_temp9 > c_AMB) begin
            if (agitate) begin
               w_temp_nxt = (w_temp9 >= c_AMB + 9'd2) ? temp - 8'd2 : c_AMB[7:0];
            end else begin
               w_temp_nxt = temp - 8'd1;
            end
         end else if (w_temp9 < c_AMB) begin
            w_temp_nxt = temp + 8'd1;
         end
      end
   end

   // Free-running thermal and flow prescalers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_heat_cnt <= 16'd0;
         r_flow_cnt <= 16'd0;
      end else begin
         r_heat_cnt <= w_htick ? 16'd0 : r_heat_cnt + 16'd1;
         r_flow_cnt <= w_ftick ? 16'd0 : r_flow_cnt + 16'd1;
      end
   end

   // Previous chute value for rising-edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_chute_q <= 1'b0;
      end else begin
         r_chute_q <= chute;
      end
   end

   // Plant state registers; faults and grain flag are sticky until reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         temp         <= 8'(INIT_TEMP);
         level        <= 8'(INIT_LEVEL);
         tank_level   <= 8'd0;
         grain_loaded <= 1'b0;
         fault        <= 3'b000;
      end else begin
         temp         <= w_temp_nxt;
         level        <= w_level_nxt;
         tank_level   <= w_tank_nxt;
         grain_loaded <= grain_loaded | w_grain_ok;
         fault        <= fault | {w_pump_bad, w_overflow, w_dry_fire};
      end
   end

endmodule
`default_nettype wire

// File: doc/brew_plant.md
BREW_PLANT -- requirements
Module: brew_plant

Interface
REQ-001 Parameters (name, default, meaning):
- HEAT_DIV, 4: clock cycles per thermal tick.
- FLOW_DIV, 2: clock cycles per flow tick.
- FILL_RATE, 5: level units added per flow tick.
- DRAIN_RATE, 5: level units removed per flow tick.
- GRAIN_VOL, 10: level units added per grain drop.
- AMBIENT, 20: ambient temperature.
- T_MAX, 100: boil clamp.
- L_MAX, 200: kettle capacity.
- INIT_TEMP, 20: temp after reset.
- INIT_LEVEL, 0: level after reset.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: the single clock.
- reset, in, 1: asynchronous active-low reset.
- heat, in, 1: heater on.
- agitate, in, 1: agitator on.
- chute, in, 1: grain chute open.
- pump, in, 3: pump route {IN, OUT, TANK}.
- temp, out, 8: kettle temperature.
- level, out, 8: kettle level.
- tank_level, out, 8: holding-tank level.
- grain_loaded, out, 1: sticky, grain dropped.
- fault, out, 3: sticky {illegal_pump, overflow, dry_fire}.

Function
REQ-003 The block SHALL model the kettle plant driven by the brew controller; all outputs SHALL be registered and updated only on rising clk.
REQ-004 Thermal prescaler SHALL count 0..HEAT_DIV-1 from reset release and assert a thermal tick on the cycle it equals HEAT_DIV-1, then wrap to 0; the first tick occurs on cycle HEAT_DIV.
REQ-005 Flow prescaler SHALL behave identically with FLOW_DIV, independently of the thermal prescaler.
REQ-006 On a thermal tick with heat=1, temp SHALL increment by 1, saturating at T_MAX.
REQ-007 On a thermal tick with heat=0, temp SHALL decrement toward AMBIENT (by 2 if agitate=1, else 1), never below AMBIENT; a temp already below AMBIENT SHALL increment by 1.
REQ-008 On a thermal tick with heat=1 and level=0, fault[0] (dry_fire) SHALL set; temp still rises.
REQ-009 Pump decode on a flow tick:
- 000: no flow.
- 100 (WATER): level += FILL_RATE.
- 111 (SPARGE): level += FILL_RATE.
- 010 (WASTE): level -= DRAIN_RATE.
- 011 (TO_TANK): level -= DRAIN_RATE and tank_level += the amount actually removed.
- 101 (FROM_TANK): tank_level -= DRAIN_RATE and level += the amount actually removed.
REQ-010 Pump codes 001 and 110 SHALL cause no flow and SHALL set fault[2] on the next clock edge, whether or not a flow tick occurs.
REQ-011 All level arithmetic SHALL use 9-bit intermediates.
- Decrements SHALL clamp at 0.
- Kettle increments SHALL clamp at L_MAX; any clamp at L_MAX sets fault[1].
- tank_level SHALL clamp at 255 with no fault.
REQ-012 A rising edge of chute (registered previous value) with level>0 SHALL add GRAIN_VOL to level and set grain_loaded.
REQ-013 A chute rising edge with level=0 SHALL set fault[0] and leave level and grain_loaded unchanged.
REQ-014 A held-high chute SHALL add grain only once.
REQ-015 A chute edge and a flow tick in the same cycle SHALL both apply to level: flow delta plus GRAIN_VOL, clamped once per REQ-011.
REQ-016 Simultaneous thermal and flow ticks SHALL both apply in that cycle.
REQ-017 Inputs SHALL be sampled on the tick cycle; the effect SHALL be visible on outputs after that edge (latency 1 cycle from tick).
REQ-018 fault bits and grain_loaded SHALL remain set until reset.

Reset
REQ-019 While reset=0, asynchronously, independent of clk, outputs SHALL take these values:
- temp = INIT_TEMP
- level = INIT_LEVEL
- tank_level = 0
- grain_loaded = 0
- fault = 000
REQ-020 While reset=0, both prescalers SHALL be 0 and the chute edge register SHALL be 0.
REQ-021 Reset asserted mid-tick SHALL discard the pending tick; after release, the first ticks follow REQ-004 and REQ-005.

Verification
REQ-022 The bench SHALL cover these directed scenarios (defaults unless stated):
- Fill: release reset, pump=100 for 50 cycles -> level 125, tank_level 0, fault 000.
- Heat: level 125, heat=1 for 160 cycles from temp 20 -> temp 60; continue 400 cycles -> temp 100 held.
- Transfer: level 125, pump=011 for 60 cycles -> level 0, tank_level 125, no underflow.
- Cool: heat=0, agitate=1, temp 60, 40 cycles -> temp 40; hold -> 20.
- Faults: pump=110 -> fault=100 next cycle, level unchanged, persists after pump=000; fill past 200 -> level 200, fault[1]=1.
- Grain/reset: level 125, chute held 10 cycles -> level 135, grain_loaded=1; assert reset mid-fill between edges -> level 0, fault 000 immediately.
